// File: rtl/pokey_pkg.sv
// Shared constants and FSM encoding for the POKEY keyboard scan path.
package pokey_pkg;

  localparam int         KEY_BITS_DEF  = 6;
  localparam int         SCAN_DIV_DEF  = 114;
  localparam int         DEBOUNCE_DEF  = 2;
  localparam logic [5:0] SHIFT_IDX_DEF = 6'h3E;
  localparam logic [5:0] CTRL_IDX_DEF  = 6'h3C;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } scan_state_t;

endpackage

// File: rtl/pokey_scan_timer.sv
// Prescaler plus scan index counter; step is high on the last prescaler count.
// Both counters are held at zero while enable is low.
module pokey_scan_timer
  import pokey_pkg::*;
#(
  parameter int KEY_BITS = KEY_BITS_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic                o2,
  input  logic                rst_L,
  input  logic                enable,
  output logic                step,
  output logic [KEY_BITS-1:0] idx
);

  localparam int            PW       = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler;

  assign step = enable && (prescaler == PRE_LAST);

  always_ff @(posedge o2 or negedge rst_L) begin
    if (!rst_L) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (!enable) begin
      prescaler <= '0;
      idx       <= '0;
    end else if (step) begin
      prescaler <= '0;
      idx       <= idx + KEY_BITS'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

endmodule

// File: rtl/pokey_key_scanner.sv
// Keyboard scan engine: debounced key latch with shift/ctrl capture and a held irq.
// All key decisions happen on scan step edges; irq_ack is taken on any o2 edge.
module pokey_key_scanner
  import pokey_pkg::*;
#(
  parameter int                  KEY_BITS  = KEY_BITS_DEF,
  parameter int                  SCAN_DIV  = SCAN_DIV_DEF,
  parameter int                  DEBOUNCE  = DEBOUNCE_DEF,
  parameter logic [KEY_BITS-1:0] SHIFT_IDX = KEY_BITS'(SHIFT_IDX_DEF),
  parameter logic [KEY_BITS-1:0] CTRL_IDX  = KEY_BITS'(CTRL_IDX_DEF)
) (
  input  logic                o2,
  input  logic                rst_L,
  input  logic                enable,
  input  logic                debounce_en,
  input  logic                kr1_L,
  input  logic                kr2_L,
  input  logic                irq_ack,
  output logic [KEY_BITS-1:0] key_scan_L,
  output logic [KEY_BITS+1:0] kbcode,
  output logic                key_held,
  output logic                shift_held,
  output logic                key_irq,
  output logic                overrun
);

  localparam int          CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW:0] NEED_DB  = (CW + 1)'(DEBOUNCE);
  localparam logic [CW:0] NEED_ONE = (CW + 1)'(1);

  logic                step;
  logic [KEY_BITS-1:0] idx;
  scan_state_t         state;
  logic [KEY_BITS-1:0] cand;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       miss;
  logic                ctrl;
  logic [CW:0]         need;
  logic [CW:0]         cnt_inc;
  logic [CW:0]         miss_inc;
  logic                on_cand;
  logic                latch;

  pokey_scan_timer #(
    .KEY_BITS (KEY_BITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .o2     (o2),
    .rst_L  (rst_L),
    .enable (enable),
    .step   (step),
    .idx    (idx)
  );

  assign key_scan_L = ~idx;
  assign need       = debounce_en ? NEED_DB : NEED_ONE;
  assign cnt_inc    = {1'b0, cnt} + NEED_ONE;
  assign miss_inc   = {1'b0, miss} + NEED_ONE;
  assign on_cand    = (idx == cand);

  // A latch in CONFIRM implies idx == cand, so idx is the latched code either way.
  always_comb begin
    latch = 1'b0;
    if (step) begin
      case (state)
        ST_IDLE:    latch = !kr1_L && (need == NEED_ONE);
        ST_CONFIRM: latch = on_cand && !kr1_L && (cnt_inc >= need);
        default:    latch = 1'b0;
      endcase
    end
  end

  always_ff @(posedge o2 or negedge rst_L) begin
    if (!rst_L) begin
      state      <= ST_IDLE;
      cand       <= '0;
      cnt        <= '0;
      miss       <= '0;
      kbcode     <= '0;
      key_held   <= 1'b0;
      shift_held <= 1'b0;
      ctrl       <= 1'b0;
      key_irq    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (latch)        key_irq <= 1'b1;
      else if (irq_ack) key_irq <= 1'b0;

      if (irq_ack)                 overrun <= 1'b0;
      else if (latch && key_irq)   overrun <= 1'b1;

      if (latch) kbcode <= {ctrl, shift_held, idx};

      if (step && (idx == SHIFT_IDX)) shift_held <= ~kr2_L;
      if (step && (idx == CTRL_IDX))  ctrl       <= ~kr2_L;

      if (!enable) begin
        state    <= ST_IDLE;
        key_held <= 1'b0;
        cnt      <= '0;
        miss     <= '0;
      end else if (step) begin
        case (state)
          ST_IDLE: begin
            if (!kr1_L) begin
              cand  <= idx;
              cnt   <= CW'(1);
              state <= latch ? ST_HELD : ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (on_cand) begin
              if (kr1_L)              state <= ST_IDLE;
              else if (latch)         state <= ST_HELD;
              else if (!cnt_inc[CW])  cnt   <= cnt_inc[CW-1:0];
            end
          end
          ST_HELD: begin
            if (on_cand) begin
              if (!kr1_L) begin
                miss <= '0;
              end else if (miss_inc >= need) begin
                miss     <= '0;
                key_held <= 1'b0;
                state    <= ST_IDLE;
              end else if (!miss_inc[CW]) begin
                miss <= miss_inc[CW-1:0];
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
        if (latch) begin
          key_held <= 1'b1;
          miss     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pokey_key_scanner.sv
// Bench for pokey_key_scanner: keyboard matrix model, behavioural reference and per-cycle compare.
module tb_pokey_key_scanner;

  localparam int         SCAN_DIV = 4;
  localparam int         DEBOUNCE = 2;
  localparam logic [5:0] SHIFT_I  = 6'h3E;
  localparam logic [5:0] CTRL_I   = 6'h3C;

  logic       o2 = 1'b0;
  logic       rst_L, enable, debounce_en, kr1_L, kr2_L, irq_ack;
  logic [5:0] key_scan_L;
  logic [7:0] kbcode;
  logic       key_held, shift_held, key_irq, overrun;

  int checks = 0;
  int errors = 0;
  logic run_chk;

  logic [63:0] pressed;
  logic        shift_down, ctrl_down;

  int         m_pre, m_hits, m_miss;
  logic [5:0] m_idx, m_cand;
  logic [7:0] m_kb;
  logic       m_tracking, m_latched, m_shift, m_ctrl, m_irq, m_ovr;

  always #5 o2 = ~o2;

  pokey_key_scanner #(
    .KEY_BITS  (6),
    .SCAN_DIV  (SCAN_DIV),
    .DEBOUNCE  (DEBOUNCE),
    .SHIFT_IDX (SHIFT_I),
    .CTRL_IDX  (CTRL_I)
  ) dut (
    .o2          (o2),
    .rst_L       (rst_L),
    .enable      (enable),
    .debounce_en (debounce_en),
    .kr1_L       (kr1_L),
    .kr2_L       (kr2_L),
    .irq_ack     (irq_ack),
    .key_scan_L  (key_scan_L),
    .kbcode      (kbcode),
    .key_held    (key_held),
    .shift_held  (shift_held),
    .key_irq     (key_irq),
    .overrun     (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge o2);
    #2;
  endtask

  // Key matrix: the return lines follow whichever index the scan is currently on.
  always @(negedge o2) begin
    #1;
    kr1_L = !pressed[m_idx];
    kr2_L = !(((m_idx == SHIFT_I) && shift_down) || ((m_idx == CTRL_I) && ctrl_down));
  end

  // Reference: a step happens every SCAN_DIV edges; presses count consecutive hits on one key.
  always @(posedge o2 or negedge rst_L) begin
    bit stp, down, lat;
    int need;
    if (!rst_L) begin
      m_pre = 0; m_idx = 0; m_tracking = 0; m_latched = 0; m_hits = 0; m_miss = 0;
      m_cand = 0; m_kb = 0; m_shift = 0; m_ctrl = 0; m_irq = 0; m_ovr = 0;
    end else begin
      stp  = enable && (m_pre == SCAN_DIV - 1);
      down = !kr1_L;
      need = debounce_en ? DEBOUNCE : 1;
      lat  = 0;
      if (stp) begin
        if (!m_latched) begin
          if (!m_tracking) begin
            if (down) begin
              m_tracking = 1; m_cand = m_idx; m_hits = 1;
              lat = (m_hits >= need);
            end
          end else if (m_idx == m_cand) begin
            if (down) begin
              m_hits++;
              lat = (m_hits >= need);
            end else m_tracking = 0;
          end
          if (lat) begin
            m_tracking = 0; m_latched = 1; m_miss = 0;
            m_kb = {m_ctrl, m_shift, m_cand};
          end
        end else if (m_idx == m_cand) begin
          if (down) m_miss = 0;
          else begin
            m_miss++;
            if (m_miss >= need) begin m_latched = 0; m_miss = 0; end
          end
        end
        if (m_idx == SHIFT_I) m_shift = !kr2_L;
        if (m_idx == CTRL_I)  m_ctrl  = !kr2_L;
      end
      m_ovr = irq_ack ? 1'b0 : (m_ovr || (lat && m_irq));
      m_irq = lat ? 1'b1 : (irq_ack ? 1'b0 : m_irq);
      if (!enable) begin
        m_pre = 0; m_idx = 0; m_tracking = 0; m_latched = 0; m_miss = 0;
      end else if (stp) begin
        m_pre = 0; m_idx = m_idx + 6'd1;
      end else m_pre++;
    end
  end

  always @(negedge o2) begin
    logic [5:0] exp_scan;
    if (rst_L && run_chk) begin
      exp_scan = ~m_idx;
      check("cyc_scan",     key_scan_L, exp_scan);
      check("cyc_kbcode",   kbcode,     m_kb);
      check("cyc_held",     key_held,   m_latched);
      check("cyc_shift",    shift_held, m_shift);
      check("cyc_irq",      key_irq,    m_irq);
      check("cyc_overrun",  overrun,    m_ovr);
    end
  end

  initial begin
    bit hit;
    rst_L = 1; enable = 1; debounce_en = 1; irq_ack = 0; pressed = '0;
    shift_down = 0; ctrl_down = 0; kr1_L = 1; kr2_L = 1; run_chk = 0;
    #2 rst_L = 0;
    repeat (3) @(negedge o2);
    rst_L = 1; run_chk = 1;
    #2;
    check("rst_scan", key_scan_L, 6'h3F);
    check("rst_kbcode", kbcode, 8'h00);
    check("rst_irq", {key_held, shift_held, key_irq, overrun}, 4'b0000);
    cyc(4);   check("scan_step1", key_scan_L, 6'h3E);
    cyc(252); check("scan_wrap", key_scan_L, 6'h3F);

    // debounced press: confirm on pass 1, latch on pass 2 at idx 0x12
    pressed[6'h12] = 1;
    cyc(331); check("db_pass1_irq", key_irq, 1'b0);
    cyc(1);
    check("db_latch_irq", key_irq, 1'b1);
    check("db_latch_code", kbcode, 8'h12);
    check("db_latch_held", key_held, 1'b1);

    // bounce: one missed pass keeps the key held
    pressed[6'h12] = 0; cyc(256); check("bounce_held1", key_held, 1'b1);
    pressed[6'h12] = 1; cyc(256); check("bounce_held2", key_held, 1'b1);
    pressed[6'h12] = 0; cyc(256); check("release_pass1", key_held, 1'b1);
    cyc(256); check("release_pass2", key_held, 1'b0);

    pressed[6'h20] = 1; cyc(512);
    check("ovr_code", kbcode, 8'h20);
    check("ovr_set", overrun, 1'b1);
    irq_ack = 1; cyc(1); irq_ack = 0;
    check("ack_irq", key_irq, 1'b0);
    check("ack_ovr", overrun, 1'b0);
    pressed[6'h20] = 0; cyc(512); check("rel20_held", key_held, 1'b0);

    shift_down = 1; pressed[6'h05] = 1; cyc(512);
    check("mod_code", kbcode, 8'h45);
    check("mod_shift", shift_held, 1'b1);
    pressed[6'h05] = 0; shift_down = 0; cyc(512);
    check("mod_release", {key_held, shift_held}, 2'b00);

    // irq still pending from 0x45; ack on the latch edge of 0x12
    pressed[6'h12] = 1;
    hit = 0;
    for (int i = 0; i < 700 && !hit; i++) begin
      if (m_tracking && m_idx == m_cand && m_pre == SCAN_DIV - 1 && m_hits + 1 >= DEBOUNCE)
        hit = 1;
      else cyc(1);
    end
    check("ack_latch_found", hit, 1'b1);
    irq_ack = 1; cyc(1); irq_ack = 0;
    check("ack_latch_irq", key_irq, 1'b1);
    check("ack_latch_ovr", overrun, 1'b0);
    check("ack_latch_code", kbcode, 8'h12);
    pressed[6'h12] = 0; cyc(512);

    debounce_en = 0; pressed[6'h30] = 1; cyc(256);
    check("nodb_code", kbcode, 8'h30);
    check("nodb_held", key_held, 1'b1);
    pressed[6'h30] = 0; cyc(256);
    check("nodb_release", key_held, 1'b0);
    debounce_en = 1;

    pressed[6'h21] = 1;
    for (int i = 0; i < 600 && !m_tracking; i++) cyc(1);
    check("confirm_found", m_tracking, 1'b1);
    enable = 0; cyc(1);
    check("dis_scan", key_scan_L, 6'h3F);
    check("dis_code", kbcode, 8'h30);
    check("dis_held", key_held, 1'b0);
    pressed[6'h21] = 0; enable = 1; cyc(512);
    check("dis_no_latch", kbcode, 8'h30);

    pressed[6'h07] = 1; cyc(512);
    check("pre_rst_held", key_held, 1'b1);
    rst_L = 0; #1;
    check("mid_rst_scan", key_scan_L, 6'h3F);
    check("mid_rst_code", kbcode, 8'h00);
    check("mid_rst_flags", {key_held, shift_held, key_irq, overrun}, 4'b0000);
    pressed[6'h07] = 0;
    cyc(2); rst_L = 1;

    for (int seg = 0; seg < 30; seg++) begin
      int dur, nk;
      pressed = '0;
      nk = $urandom_range(0, 2);
      for (int k = 0; k < nk; k++) pressed[$urandom_range(0, 63)] = 1;
      shift_down  = ($urandom_range(0, 1) == 1);
      ctrl_down   = ($urandom_range(0, 1) == 1);
      debounce_en = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 7) != 0);
      dur = $urandom_range(20, 600);
      for (int c = 0; c < dur; c++) begin
        irq_ack = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 199) == 0) pressed[$urandom_range(0, 63)] ^= 1'b1;
        cyc(1);
      end
      irq_ack = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pokey_key_scanner.md
Name: pokey_key_scanner

Overview:
- Parametrised keyboard scan engine for the POKEY I/O path; generalises the fixed 6-bit key scan.
- Drives an inverted binary scan index onto the key matrix and samples the key return lines kr1_L/kr2_L.
- Debounces presses, latches the key code together with shift/ctrl modifiers, and raises a held interrupt request with overrun detection.
- Sits under IOControl. Its kbcode, key_held and key_irq outputs feed the KBCODE/SKSTAT/IRQST registers.

Parameters:
- KEY_BITS, 6: scan index width; 2^KEY_BITS keys.
- SCAN_DIV, 114: o2 cycles per scan step; must be >= 2.
- DEBOUNCE, 2: consecutive matching passes needed to accept a press or a release; must be >= 1.
- SHIFT_IDX, 6'h3E: scan index at which kr2_L low means shift is held.
- CTRL_IDX, 6'h3C: scan index at which kr2_L low means ctrl is held.

Ports:
- o2  input  1  phase-2 clock; the only clock.
- rst_L  input  1  reset, asynchronous, active-low.
- enable  input  1  scan enable (SKCTL keyboard-scan bit).
- debounce_en  input  1  1 = DEBOUNCE passes required; 0 = accept on first detection.
- kr1_L  input  1  key return, active-low.
- kr2_L  input  1  modifier return, active-low.
- irq_ack  input  1  one-cycle acknowledge; clears key_irq and overrun.
- key_scan_L  output  KEY_BITS  inverted scan index.
- kbcode  output  KEY_BITS+2  {ctrl, shift, code} captured at latch time.
- key_held  output  1  a latched key is still down.
- shift_held  output  1  live shift status.
- key_irq  output  1  key-event request; held until acknowledged.
- overrun  output  1  sticky: a new key was latched while key_irq was already 1.

Behaviour:
- Reset (async, rst_L low): prescaler=0, idx=0 so key_scan_L = all ones, state=IDLE, kbcode=0, key_held=0, shift_held=0, ctrl reg=0, key_irq=0, overrun=0, cand=0, cnt=0.
- Step edge: the o2 edge where prescaler==SCAN_DIV-1.
  - All sampling, FSM updates and the idx increment happen on this edge.
  - kr1_L/kr2_L are sampled against the current idx.
  - idx wraps from 2^KEY_BITS-1 to 0.
  - prescaler wraps to 0.
- Modifiers: on the step edge at SHIFT_IDX, shift_held = ~kr2_L. At CTRL_IDX, the ctrl reg = ~kr2_L. These update in every state.
- enable=0: prescaler and idx are forced to 0, state forced to IDLE, key_held=0. kbcode, key_irq, overrun and the modifiers are retained.
- FSM, evaluated on step edges only:
  - IDLE: kr1_L low at index i → cand=i. If debounce_en=0 or DEBOUNCE=1, latch immediately. Otherwise cnt=1 and go to CONFIRM.
  - CONFIRM: only idx==cand is examined; other keys are ignored (first-found priority).
    - kr1_L low → cnt+1; when it reaches DEBOUNCE, latch.
    - kr1_L high → IDLE.
  - Latch action:
    - kbcode={ctrl, shift_held, cand}, using the modifier values before this edge.
    - key_held=1, go to HELD.
    - key_irq=1; if key_irq was already 1, overrun=1.
  - HELD: only idx==cand is examined; no rollover, so other presses are ignored.
    - kr1_L low → miss=0.
    - kr1_L high → miss+1; when miss reaches DEBOUNCE (or 1 when debounce_en=0), key_held=0 and go to IDLE.
- irq_ack is accepted on any o2 edge: key_irq=0, overrun=0.
- irq_ack on the same edge as a latch: key_irq=1 and overrun=0 (the ack consumes the old event).
- Counter widths: cnt and miss are ceil(log2(DEBOUNCE+1)) bits and saturate; no wrap.
- Reset mid-operation: the async return to the reset values above; no partial latch survives.

Decomposition:
- Shared package pokey_pkg holds:
  - the FSM state encoding (IDLE, CONFIRM, HELD);
  - default KEY_BITS/SCAN_DIV constants;
  - the modifier index constants.
- Sub-module pokey_scan_timer: prescaler plus idx counter with enable/wrap, producing step and idx.
- FSM and latch logic stay in pokey_key_scanner.

Test Plan (KEY_BITS=6, SCAN_DIV=4, DEBOUNCE=2, SHIFT_IDX=6'h3E, CTRL_IDX=6'h3C; one pass = 256 o2 cycles):
- Reset/scan: release rst_L with enable=1, kr lines high → key_scan_L=6'h3F, all outputs 0. After 4 cycles key_scan_L=6'h3E; after 256 cycles it is 6'h3F again.
- Debounced press: kr1_L low whenever idx==6'h12 → nothing on pass 1. On the pass-2 step edge at idx 6'h12: kbcode=8'h12, key_irq=1, key_held=1.
- Modifier: kr2_L low at idx 6'h3E, then key 6'h05 held for 2 passes → kbcode=8'h45, shift_held=1.
- Overrun/ack: latch 6'h12, release for 2 passes, then latch 6'h20 without ack → overrun=1, kbcode=8'h20. Pulse irq_ack → key_irq=0, overrun=0. Ack coinciding with a latch → key_irq=1, overrun=0.
- Release/bounce: in HELD, kr1_L high at 6'h12 for 1 pass then low → key_held stays 1. High for 2 passes → key_held=0, state IDLE.
- Mode/abort: debounce_en=0 → latch on first detection. enable=0 in CONFIRM → key_scan_L=6'h3F, IDLE, kbcode retained. rst_L low in HELD → immediate reset values.
